// File: rtl/prog_encoder_pkg.sv
// Shared types for the program encoder: op codes, FSM states, packed-word bundle.
package prog_encoder_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned IMM_W  = 5;
  localparam int unsigned WORD_W = 9;

  localparam logic [WORD_W-1:0] halt_word = 9'h1FF;

  typedef enum logic [OP_W-1:0] {
    op_lsl  = 5'd0,
    op_lsr  = 5'd1,
    op_ld   = 5'd2,
    op_st   = 5'd3,
    op_sbs  = 5'd4,
    op_dbs  = 5'd5,
    op_xor  = 5'd6,
    op_rxr  = 5'd7,
    op_jmp  = 5'd8,
    op_spc  = 5'd9,
    op_lut  = 5'd10,
    op_ctc  = 5'd11,
    op_cti  = 5'd12,
    op_cts  = 5'd13,
    op_cbf  = 5'd14,
    op_cpy  = 5'd15,
    op_or   = 5'd16,
    op_add  = 5'd17,
    op_mov  = 5'd18,
    op_halt = 5'd19,
    op_ldi  = 5'd20,
    op_inc  = 5'd21
  } op_e;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_exp2 = 2'd2,
    st_done = 2'd3
  } state_e;

  // word1 is only meaningful when macro is set
  typedef struct packed {
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic              legal;
    logic              macro;
    logic              halt;
  } pack_t;

endpackage

// File: rtl/prog_encoder_insn_pack.sv
// Combinational packer: symbolic request -> up to two 9-bit machine words plus legality.
module prog_encoder_insn_pack
  import prog_encoder_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [IMM_W-1:0] imm,
  input  logic             flag,
  output pack_t            pk
);

  always_comb begin
    pk       = '0;
    pk.legal = 1'b1;
    case (op)
      op_lsl:  pk.word0 = {3'b000, rd, rs};
      op_lsr:  pk.word0 = {3'b001, rd, rs};
      op_ld:   pk.word0 = {5'b01000, rd, 1'b0};
      op_st:   pk.word0 = {5'b01001, rs, 1'b0};
      op_sbs:  pk.word0 = {5'b01010, rd, 1'b0};
      op_dbs:  pk.word0 = {5'b01011, rd, 1'b0};
      op_xor:  pk.word0 = {4'b0110, rd, 2'b00};
      op_rxr:  pk.word0 = {4'b0111, rd, 2'b00};
      op_jmp:  pk.word0 = {4'b1000, flag, imm[1:0], 2'b00};
      op_spc:  pk.word0 = {4'b1001, imm[1:0], flag, 2'b00};
      op_lut:  pk.word0 = {4'b1010, rs, flag, 1'b0};
      op_ctc:  pk.word0 = {6'b101100, imm[1:0], 1'b0};
      op_cti:  pk.word0 = {6'b101101, imm[1:0], 1'b0};
      op_cts:  pk.word0 = {6'b101110, imm[1:0], 1'b0};
      op_cbf:  pk.word0 = {6'b101111, 3'b000};
      op_cpy:  pk.word0 = {4'b1100, rd, 2'b00};
      // OR only addresses the upper register bank
      op_or: begin
        pk.word0 = {4'b1101, rd, rs[1:0]};
        pk.legal = rs[2];
      end
      op_add:  pk.word0 = {4'b1110, rd, flag, 1'b0};
      // MOV 31 would alias the halt word
      op_mov: begin
        pk.word0 = {4'b1111, imm};
        pk.legal = (imm != 5'd31);
      end
      op_halt: begin
        pk.word0 = halt_word;
        pk.halt  = 1'b1;
      end
      op_ldi: begin
        pk.word0 = {4'b1111, imm};
        pk.word1 = {4'b1100, rd, 2'b00};
        pk.macro = 1'b1;
        pk.legal = (imm != 5'd31);
      end
      op_inc: begin
        pk.word0 = {4'b1111, 5'd1};
        pk.word1 = {6'b101101, imm[1:0], 1'b0};
        pk.macro = 1'b1;
      end
      default: pk.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: accepts symbolic requests, writes packed words sequentially into instruction memory.
module prog_encoder
  import prog_encoder_pkg::*;
#(
  parameter int unsigned A_W   = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [A_W-1:0]    base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [REG_W-1:0]  req_rd,
  input  logic [REG_W-1:0]  req_rs,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic              req_flag,
  output logic              inst_wr_en,
  output logic [A_W-1:0]    inst_wr_addr,
  output logic [WORD_W-1:0] inst_wr_data,
  output logic              done,
  output logic              err,
  output logic [A_W:0]      word_count
);

  localparam logic [A_W-1:0] last_addr = A_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [A_W-1:0]      ptr_q, ptr_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                ready_d, en_d, done_d, err_d;
  logic [A_W-1:0]      addr_d;
  logic [WORD_W-1:0]   data_d;
  logic [A_W:0]        cnt_d;
  logic                wr_go;
  logic [WORD_W-1:0]   wr_word;
  logic                overflow;
  pack_t               pk;

  prog_encoder_insn_pack u_pack (
    .op   (req_op),
    .rd   (req_rd),
    .rs   (req_rs),
    .imm  (req_imm),
    .flag (req_flag),
    .pk   (pk)
  );

  // The reserved last slot belongs to halt; anything else landing there is dropped
  assign overflow = (ptr_q >= last_addr);

  // Next-state, pointer and output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    en_d    = 1'b0;
    addr_d  = inst_wr_addr;
    data_d  = inst_wr_data;
    done_d  = done;
    err_d   = err;
    cnt_d   = word_count;
    wr_go   = 1'b0;
    wr_word = '0;

    if (start) begin
      state_d = st_run;
      ptr_d   = base_addr;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        st_run: begin
          if (req_valid) begin
            if (!pk.legal) begin
              err_d = 1'b1;
            end else if (pk.halt) begin
              wr_go   = 1'b1;
              wr_word = halt_word;
              done_d  = 1'b1;
              state_d = st_done;
            end else if (overflow) begin
              err_d = 1'b1;
            end else begin
              wr_go   = 1'b1;
              wr_word = pk.word0;
              if (pk.macro) begin
                hold_d  = pk.word1;
                state_d = st_exp2;
              end
            end
          end
        end
        st_exp2: begin
          state_d = st_run;
          if (overflow) begin
            err_d = 1'b1;
          end else begin
            wr_go   = 1'b1;
            wr_word = hold_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    if (wr_go) begin
      en_d   = 1'b1;
      addr_d = ptr_q;
      data_d = wr_word;
      cnt_d  = word_count + (A_W+1)'(1);
      if (ptr_q != last_addr) begin
        ptr_d = ptr_q + A_W'(1);
      end
    end

    ready_d = (state_d == st_run);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= st_idle;
      ptr_q        <= '0;
      hold_q       <= '0;
      req_ready    <= 1'b0;
      inst_wr_en   <= 1'b0;
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      word_count   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      req_ready    <= ready_d;
      inst_wr_en   <= en_d;
      inst_wr_addr <= addr_d;
      inst_wr_data <= data_d;
      done         <= done_d;
      err          <= err_d;
      word_count   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prog_encoder.sv
// Randomized + directed bench for prog_encoder against a word-list model, on a full-depth and a 4-deep instance.
module tb_prog_encoder;

  localparam int OP_LSL = 0,  OP_LSR = 1,  OP_LD = 2,   OP_ST = 3,   OP_SBS = 4,  OP_DBS = 5;
  localparam int OP_XOR = 6,  OP_RXR = 7,  OP_JMP = 8,  OP_SPC = 9,  OP_LUT = 10, OP_CTC = 11;
  localparam int OP_CTI = 12, OP_CTS = 13, OP_CBF = 14, OP_CPY = 15, OP_OR = 16,  OP_ADD = 17;
  localparam int OP_MOV = 18, OP_HALT = 19, OP_LDI = 20, OP_INC = 21;

  logic       clk = 1'b0;
  logic       reset, start, req_valid, req_flag;
  logic [7:0] base_addr;
  logic [4:0] req_op, req_imm;
  logic [2:0] req_rd, req_rs;

  logic [1:0] o_en, o_rdy, o_done, o_err;
  logic [7:0] o_addr [2];
  logic [8:0] o_data [2];
  logic [8:0] o_cnt  [2];

  int tests = 0;
  int failed = 0;
  bit chk_on = 1'b0;

  // reference model state, one slot per instance
  int m_depth [2] = '{256, 4};
  bit m_run [2], m_done [2], m_err [2], m_en [2], m_pend [2], m_ready [2];
  int m_ptr [2], m_cnt [2], m_addr [2], m_data [2], m_pw [2];

  int log_a [$], log_d [$], log4_a [$], log4_d [$];

  always #5 clk = ~clk;

  prog_encoder u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(o_rdy[0]), .req_op(req_op), .req_rd(req_rd),
    .req_rs(req_rs), .req_imm(req_imm), .req_flag(req_flag),
    .inst_wr_en(o_en[0]), .inst_wr_addr(o_addr[0]), .inst_wr_data(o_data[0]),
    .done(o_done[0]), .err(o_err[0]), .word_count(o_cnt[0])
  );

  prog_encoder #(.A_W(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(o_rdy[1]), .req_op(req_op), .req_rd(req_rd),
    .req_rs(req_rs), .req_imm(req_imm), .req_flag(req_flag),
    .inst_wr_en(o_en[1]), .inst_wr_addr(o_addr[1]), .inst_wr_data(o_data[1]),
    .done(o_done[1]), .err(o_err[1]), .word_count(o_cnt[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word list for a request: n=0 illegal, n=1 single word, n=2 macro
  task automatic encode(input int op, input int rd, input int rs, input int imm, input int flag,
                        output int n, output int w0, output int w1, output bit halt);
    int i2;
    i2 = imm % 4;
    n = 1; w0 = 0; w1 = 0; halt = 1'b0;
    case (op)
      OP_LSL:  w0 = rd * 8 + rs;
      OP_LSR:  w0 = 'h040 + rd * 8 + rs;
      OP_LD:   w0 = 'h080 + rd * 2;
      OP_ST:   w0 = 'h090 + rs * 2;
      OP_SBS:  w0 = 'h0A0 + rd * 2;
      OP_DBS:  w0 = 'h0B0 + rd * 2;
      OP_XOR:  w0 = 'h0C0 + rd * 4;
      OP_RXR:  w0 = 'h0E0 + rd * 4;
      OP_JMP:  w0 = 'h100 + flag * 16 + i2 * 4;
      OP_SPC:  w0 = 'h120 + i2 * 8 + flag * 4;
      OP_LUT:  w0 = 'h140 + rs * 4 + flag * 2;
      OP_CTC:  w0 = 'h160 + i2 * 2;
      OP_CTI:  w0 = 'h168 + i2 * 2;
      OP_CTS:  w0 = 'h170 + i2 * 2;
      OP_CBF:  w0 = 'h178;
      OP_CPY:  w0 = 'h180 + rd * 4;
      OP_OR:   begin w0 = 'h1A0 + rd * 4 + rs % 4; if (rs < 4) n = 0; end
      OP_ADD:  w0 = 'h1C0 + rd * 4 + flag * 2;
      OP_MOV:  begin w0 = 'h1E0 + imm; if (imm == 31) n = 0; end
      OP_HALT: begin w0 = 'h1FF; halt = 1'b1; end
      OP_LDI:  begin w0 = 'h1E0 + imm; w1 = 'h180 + rd * 4; n = (imm == 31) ? 0 : 2; end
      OP_INC:  begin w0 = 'h1E1; w1 = 'h168 + i2 * 2; n = 2; end
      default: n = 0;
    endcase
  endtask

  task automatic emit(input int i, input int w, output bit ok);
    ok = 1'b0;
    if (m_ptr[i] >= m_depth[i] - 1) begin
      m_err[i] = 1'b1;
    end else begin
      m_en[i] = 1'b1; m_addr[i] = m_ptr[i]; m_data[i] = w;
      m_ptr[i]++; m_cnt[i]++;
      ok = 1'b1;
    end
  endtask

  task automatic model_step(input int i);
    int n, w0, w1;
    bit hl, ok;
    m_en[i] = 1'b0;
    if (!reset) begin
      m_run[i] = 0; m_done[i] = 0; m_err[i] = 0; m_pend[i] = 0;
      m_ptr[i] = 0; m_cnt[i] = 0; m_addr[i] = 0; m_data[i] = 0;
    end else if (start) begin
      m_run[i] = 1; m_done[i] = 0; m_err[i] = 0; m_pend[i] = 0;
      m_ptr[i] = int'(base_addr); m_cnt[i] = 0;
    end else if (m_pend[i]) begin
      m_pend[i] = 0;
      emit(i, m_pw[i], ok);
    end else if (m_run[i] && req_valid) begin
      encode(int'(req_op), int'(req_rd), int'(req_rs), int'(req_imm), int'(req_flag), n, w0, w1, hl);
      if (n == 0) begin
        m_err[i] = 1'b1;
      end else if (hl) begin
        m_en[i] = 1'b1; m_addr[i] = m_ptr[i]; m_data[i] = w0;
        m_ptr[i]++; m_cnt[i]++;
        m_done[i] = 1'b1; m_run[i] = 1'b0;
      end else begin
        emit(i, w0, ok);
        if (ok && n == 2) begin
          m_pend[i] = 1'b1; m_pw[i] = w1;
        end
      end
    end
    m_ready[i] = m_run[i] && !m_pend[i];
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Per-cycle compare of both instances against the model, plus a write log
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("en[%0d]", i),    int'(o_en[i]),   int'(m_en[i]));
        chk($sformatf("ready[%0d]", i), int'(o_rdy[i]),  int'(m_ready[i]));
        chk($sformatf("done[%0d]", i),  int'(o_done[i]), int'(m_done[i]));
        chk($sformatf("err[%0d]", i),   int'(o_err[i]),  int'(m_err[i]));
        chk($sformatf("count[%0d]", i), int'(o_cnt[i]),  m_cnt[i]);
        chk($sformatf("addr[%0d]", i),  int'(o_addr[i]), m_addr[i]);
        chk($sformatf("data[%0d]", i),  int'(o_data[i]), m_data[i]);
      end
    end
    if (o_en[0]) begin log_a.push_back(int'(o_addr[0])); log_d.push_back(int'(o_data[0])); end
    if (o_en[1]) begin log4_a.push_back(int'(o_addr[1])); log4_d.push_back(int'(o_data[1])); end
  end

  task automatic clear_logs();
    log_a.delete(); log_d.delete(); log4_a.delete(); log4_d.delete();
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds the request until the full-depth instance takes it
  task automatic send(input int op, input int rd, input int rs, input int imm, input int flag);
    bit acc;
    req_valid = 1'b1; req_op = 5'(op); req_rd = 3'(rd); req_rs = 3'(rs);
    req_imm = 5'(imm); req_flag = 1'(flag);
    acc = 1'b0;
    for (int k = 0; k < 16 && !acc; k++) begin
      acc = o_rdy[0];
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("handshake", int'(acc), 1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; req_valid = 1'b0; base_addr = '0;
    req_op = '0; req_rd = '0; req_rs = '0; req_imm = '0; req_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_on = 1'b1;
    chk("rst_en", int'(o_en[0]), 0);
    chk("rst_ready", int'(o_rdy[0]), 0);
    chk("rst_cnt", int'(o_cnt[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    // halt-terminated program at 0x10
    pulse_start(8'h10);
    clear_logs();
    send(OP_LSL, 2, 3, 0, 0);
    send(OP_ADD, 1, 0, 0, 1);
    send(OP_HALT, 0, 0, 0, 0);
    settle();
    chk("prog_n", log_a.size(), 3);
    if (log_a.size() >= 3) begin
      chk("prog_a0", log_a[0], 'h10); chk("prog_d0", log_d[0], 'h013);
      chk("prog_a1", log_a[1], 'h11); chk("prog_d1", log_d[1], 'h1C6);
      chk("prog_a2", log_a[2], 'h12); chk("prog_d2", log_d[2], 'h1FF);
    end
    chk("prog_done", int'(o_done[0]), 1);
    chk("prog_count", int'(o_cnt[0]), 3);

    // LDI expansion with a single-cycle ready bubble
    pulse_start(8'h40);
    clear_logs();
    send(OP_LDI, 5, 0, 7, 0);
    chk("ldi_ready_low", int'(o_rdy[0]), 0);
    @(negedge clk);
    chk("ldi_ready_back", int'(o_rdy[0]), 1);
    #1;
    chk("ldi_n", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      chk("ldi_a0", log_a[0], 'h40); chk("ldi_d0", log_d[0], 'h1E7);
      chk("ldi_a1", log_a[1], 'h41); chk("ldi_d1", log_d[1], 'h194);
    end

    // illegal requests leave the pointer alone
    pulse_start(8'h20);
    clear_logs();
    send(OP_MOV, 0, 0, 31, 0);
    send(OP_OR, 1, 2, 0, 0);
    settle();
    chk("illegal_n", log_a.size(), 0);
    chk("illegal_err", int'(o_err[0]), 1);
    send(OP_XOR, 3, 0, 0, 0);
    settle();
    chk("xor_n", log_a.size(), 1);
    if (log_a.size() >= 1) begin
      chk("xor_a", log_a[0], 'h20); chk("xor_d", log_d[0], 'h0CC);
    end

    // overflow into the reserved slot of the 4-deep instance
    pulse_start(8'h00);
    clear_logs();
    for (int i = 0; i < 4; i++) send(OP_CPY, i, 0, 0, 0);
    send(OP_HALT, 0, 0, 0, 0);
    settle();
    chk("ovf_n", log4_a.size(), 4);
    if (log4_a.size() >= 4) begin
      chk("ovf_d0", log4_d[0], 'h180); chk("ovf_d1", log4_d[1], 'h184);
      chk("ovf_d2", log4_d[2], 'h188);
      chk("ovf_a3", log4_a[3], 3);     chk("ovf_d3", log4_d[3], 'h1FF);
    end
    chk("ovf_err", int'(o_err[1]), 1);
    chk("ovf_done", int'(o_done[1]), 1);

    // restart in the middle of a macro, colliding with a request
    pulse_start(8'h30);
    clear_logs();
    send(OP_LDI, 2, 0, 9, 0);
    start = 1'b1; base_addr = 8'h50; req_valid = 1'b1; req_op = 5'(OP_XOR); req_rd = 3'd7;
    @(negedge clk);
    start = 1'b0; req_valid = 1'b0;
    settle();
    chk("restart_n", log_a.size(), 1);
    if (log_a.size() >= 1) chk("restart_d0", log_d[0], 'h1E9);
    send(OP_XOR, 2, 0, 0, 0);
    settle();
    chk("restart_n2", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      chk("restart_a", log_a[1], 'h50); chk("restart_d", log_d[1], 'h0C8);
    end

    // reset in the middle of LDI
    pulse_start(8'h60);
    send(OP_LDI, 1, 0, 3, 0);
    reset = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_en", int'(o_en[0]), 0);
    chk("rstmid_addr", int'(o_addr[0]), 0);
    chk("rstmid_data", int'(o_data[0]), 0);
    chk("rstmid_err", int'(o_err[0]) + int'(o_done[0]), 0);
    chk("rstmid_cnt", int'(o_cnt[0]), 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid_quiet_en", int'(o_en[0]), 0);
      chk("rstmid_quiet_rdy", int'(o_rdy[0]), 0);
    end
    req_valid = 1'b0;

    // random traffic: restarts, resets, illegal ops, halts, gaps
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = (r == 0) ? 1'b0 : 1'b1;
      start = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
      base_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      req_valid = ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
      r = int'($urandom_range(0, 99));
      if (r < 4)       req_op = 5'($urandom_range(22, 31));
      else if (r < 8)  req_op = 5'(OP_HALT);
      else             req_op = 5'($urandom_range(0, 21));
      req_rd = 3'($urandom_range(0, 7));
      req_rs = 3'($urandom_range(0, 7));
      req_imm = 5'($urandom_range(0, 31));
      req_flag = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b1; start = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
